// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and captures the
// fetched instruction plus its PC+2 for decode. Supports hazard stalls,
// branch/jump redirects, memory-not-ready bubbles, a sticky halt and a
// sticky misaligned-redirect error flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | fetching normally (stall / bubble / redirect handled here)
// ST_HALT  | frozen after HALT; redirect and stall ignored; exit via reset
module fetch_stage #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_in,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_stall,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_en,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc_inc,
    output logic             if_id_valid,
    output logic             halted,
    output logic             fetch_err
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_inc_q, pc_inc_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] pc_plus2;

    // PC increment wraps modulo 2^WIDTH by construction of the adder width.
    assign pc_plus2 = pc_q + WIDTH'(2);

    // Next-state and IF/ID update; rows are checked in priority order.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        err_d    = err_q;

        unique case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // Flush the younger instruction; a HALT sitting in IF/ID is squashed.
                    pc_d     = redirect_pc;
                    instr_d  = NOP_INSTR;
                    pc_inc_d = '0;
                    valid_d  = 1'b0;
                    if (redirect_pc[0]) begin
                        err_d = 1'b1;
                    end
                end else if (halt_in) begin
                    state_d  = ST_HALT;
                    instr_d  = NOP_INSTR;
                    pc_inc_d = '0;
                    valid_d  = 1'b0;
                end else if (stall) begin
                    // Hold PC and IF/ID: defaults already do that.
                end else if (imem_stall) begin
                    instr_d  = NOP_INSTR;
                    pc_inc_d = '0;
                    valid_d  = 1'b0;
                end else begin
                    instr_d  = imem_data;
                    pc_inc_d = pc_plus2;
                    valid_d  = 1'b1;
                    pc_d     = pc_plus2;
                end
            end
            ST_HALT: begin
                instr_d  = NOP_INSTR;
                pc_inc_d = '0;
                valid_d  = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign halted       = (state_q == ST_HALT);
    assign imem_addr    = pc_q;
    assign imem_en      = ~halted & ~stall;
    assign if_id_instr  = instr_q;
    assign if_id_pc_inc = pc_inc_q;
    assign if_id_valid  = valid_q;
    assign fetch_err    = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver applies directed and random
// stimulus, advances a behavioural model and queues the expected IF/ID
// contents; a monitor pops and compares after every rising edge.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect, halt_in, imem_stall;
    logic [15:0] redirect_pc, imem_data, imem_addr, if_id_instr, if_id_pc_inc;
    logic        imem_en, if_id_valid, halted, fetch_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] inc;
        logic        valid;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Model state
    logic [15:0] m_pc, m_instr, m_inc;
    logic        m_valid, m_halted, m_err;
    bit          m_known = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_data = mem_f(imem_addr);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt_in(halt_in), .imem_data(imem_data),
        .imem_stall(imem_stall), .imem_addr(imem_addr), .imem_en(imem_en),
        .if_id_instr(if_id_instr), .if_id_pc_inc(if_id_pc_inc),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_err(fetch_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance model.
    task automatic cyc(input logic r, input logic st, input logic rd,
                       input logic [15:0] rpc, input logic h, input logic ims);
        exp_t e;
        @(negedge clk);
        rst_n = r; stall = st; redirect = rd; redirect_pc = rpc;
        halt_in = h; imem_stall = ims;
        #1;
        if (m_known) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("imem_en", {15'd0, imem_en}, {15'd0, ~m_halted & ~st});
        end
        if (!r) begin
            m_pc = 16'h0000; m_instr = NOP; m_inc = 16'h0000;
            m_valid = 0; m_halted = 0; m_err = 0;
            m_known = 1;
        end else if (rd && !m_halted) begin
            m_pc = rpc; m_instr = NOP; m_inc = 0; m_valid = 0;
            if (rpc % 2 == 1) m_err = 1;
        end else if (h && !m_halted) begin
            m_halted = 1; m_instr = NOP; m_inc = 0; m_valid = 0;
        end else if (m_halted) begin
            m_instr = NOP; m_inc = 0; m_valid = 0;
        end else if (st) begin
            // everything holds
        end else if (ims) begin
            m_instr = NOP; m_inc = 0; m_valid = 0;
        end else begin
            m_instr = mem_f(m_pc);
            m_inc   = m_pc + 16'd2;
            m_valid = 1;
            m_pc    = m_pc + 16'd2;
        end
        e.pc = m_pc; e.instr = m_instr; e.inc = m_inc;
        e.valid = m_valid; e.halted = m_halted; e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic norm(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 16'h0, 0, 0);
    endtask

    // Monitor: compare registered outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", imem_addr, e.pc);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc_inc", if_id_pc_inc, e.inc);
                chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, e.valid});
                chk("halted", {15'd0, halted}, {15'd0, e.halted});
                chk("fetch_err", {15'd0, fetch_err}, {15'd0, e.err});
            end
        end
    end

    initial begin
        int budget;
        rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; halt_in = 0; imem_stall = 0;

        // Reset then straight-line fetch up to pc 0x10
        cyc(0, 0, 0, 16'h0, 0, 0);
        cyc(0, 1, 1, 16'h1234, 1, 1);
        norm(8);
        // Hazard stall for 3 cycles, then resume
        repeat (3) cyc(1, 1, 0, 16'h0, 0, 0);
        norm(2);
        // Redirect wins over a simultaneous stall
        cyc(1, 1, 1, 16'h0100, 0, 0);
        norm(2);
        // Redirect squashes a same-cycle HALT
        cyc(1, 0, 1, 16'h0200, 1, 0);
        norm(1);
        // Halt, then ignored redirect/stall, then reset
        cyc(1, 0, 0, 16'h0, 1, 0);
        norm(2);
        cyc(1, 0, 1, 16'h0300, 0, 0);
        cyc(1, 1, 0, 16'h0, 0, 0);
        cyc(0, 0, 0, 16'h0, 0, 0);
        norm(2);
        // Memory bubbles, then PC wrap at 0xFFFE
        cyc(1, 0, 0, 16'h0, 0, 1);
        cyc(1, 0, 0, 16'h0, 0, 1);
        cyc(1, 0, 1, 16'hFFFE, 0, 0);
        norm(3);
        // Misaligned redirect: sticky error, fetch continues unaligned
        cyc(1, 0, 1, 16'h0101, 0, 0);
        norm(3);
        cyc(1, 0, 0, 16'h0, 0, 1);
        cyc(0, 0, 0, 16'h0, 0, 0);
        norm(1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rpc;
            rpc = 16'($urandom);
            if ($urandom % 10 != 0) rpc[0] = 1'b0;
            cyc(($urandom % 60) != 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
                rpc, ($urandom % 40) == 0, ($urandom % 4) == 0);
        end

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
